// File: rtl/led7_to_bin_4_if.sv
// Bus between a 7-segment readback source and the led7_to_bin_4 decoder:
// the request side (patterns + start) and the result side (busy/done/bin/err).
interface led7_to_bin_4_if;
  logic [27:0] hex7_4;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] bin;
  logic        err;

  modport master (
    output hex7_4,
    output start,
    input  busy,
    input  done,
    input  bin,
    input  err
  );

  modport slave (
    input  hex7_4,
    input  start,
    output busy,
    output done,
    output bin,
    output err
  );
endinterface

// File: rtl/led7_to_bin_4.sv
// Decodes four active-low 7-segment patterns to BCD, then converts the BCD
// value to a 16-bit binary number with a reverse double-dabble, one shift per clock.
module led7_to_bin_4 (
  input  logic            clk,
  input  logic            rst_n,
  led7_to_bin_4_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] bcd;
  logic [15:0] binreg;
  logic [3:0]  cnt;
  logic [15:0] bin_q;
  logic        err_q;
  logic        done_q;

  logic [15:0] bcd_in;
  logic        all_valid;
  logic [31:0] shifted;
  logic [15:0] bcd_nxt;

  logic        busy;
  logic        accept;
  logic        finish_ok;
  logic        finish_err;

  // Returns {valid, digit}; a blank digit reads as a valid zero.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = {1'b1, 4'd0};
      7'h79:   r = {1'b1, 4'd1};
      7'h24:   r = {1'b1, 4'd2};
      7'h30:   r = {1'b1, 4'd3};
      7'h19:   r = {1'b1, 4'd4};
      7'h12:   r = {1'b1, 4'd5};
      7'h02:   r = {1'b1, 4'd6};
      7'h78:   r = {1'b1, 4'd7};
      7'h00:   r = {1'b1, 4'd8};
      7'h10:   r = {1'b1, 4'd9};
      7'h7F:   r = {1'b1, 4'd0};
      default: r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  // Undo the "add 3" of the forward conversion: a nibble that received a
  // shifted-in 8 is corrected back to a proper BCD digit.
  function automatic logic [3:0] fix_nibble(input logic [3:0] n);
    return (n >= 4'd8) ? (n - 4'd3) : n;
  endfunction

  always_comb begin
    logic [4:0] dec;
    bcd_in    = '0;
    all_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec               = seg_decode(bus.hex7_4[i*7 +: 7]);
      bcd_in[i*4 +: 4]  = dec[3:0];
      all_valid         = all_valid & dec[4];
    end
  end

  always_comb begin
    shifted = {bcd, binreg} >> 1;
    bcd_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      bcd_nxt[i*4 +: 4] = fix_nibble(shifted[16 + i*4 +: 4]);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = all_valid ? CONV : ERR;
        end
      end
      CONV: begin
        if (cnt == 4'd15) begin
          state_nxt = IDLE;
        end
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy       = 1'b0;
    accept     = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state)
      IDLE: accept = bus.start;
      CONV: begin
        busy      = 1'b1;
        finish_ok = (cnt == 4'd15);
      end
      ERR: begin
        busy       = 1'b1;
        finish_err = 1'b1;
      end
      default: ;
    endcase
  end

  // Conversion datapath: load on accept, shift-and-correct while converting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd    <= '0;
      binreg <= '0;
      cnt    <= '0;
    end else if (accept) begin
      bcd    <= bcd_in;
      binreg <= '0;
      cnt    <= '0;
    end else if (state == CONV) begin
      bcd    <= bcd_nxt;
      binreg <= shifted[15:0];
      cnt    <= cnt + 4'd1;
    end
  end

  // Result registers: only touched on the edge that raises done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish_ok | finish_err;
      if (finish_ok) begin
        bin_q <= shifted[15:0];
        err_q <= 1'b0;
      end else if (finish_err) begin
        bin_q <= '0;
        err_q <= 1'b1;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.bin  = bin_q;
  assign bus.err  = err_q;

endmodule
